// File: rtl/vblank_scheduler.sv
// vblank_scheduler
//   Grants a shared, frame-visible update resource to one game-state
//   requester at a time, round-robin, only during vertical blanking.
//   A frame starts when the sync counters reach (vcnt == V_ACTIVE, hcnt == 0):
//   the current requests are latched and served one by one. Work still open
//   when the counters wrap to (0, 0) is discarded and reported.
//
// Ports
//   clk          pixel clock
//   reset        synchronous, active-high
//   hcnt, vcnt   sync generator counters
//   req          per-requester update request (level, latched at frame start)
//   done         per-requester completion (only the granted bit is looked at)
//   grant        registered one-hot grant, or zero
//   frame_tick   one-cycle pulse after the vblank-start edge
//   busy         scheduler is not idle
//   overrun      sticky: a vblank ended with requests unserved
//   skipped      requesters discarded at the most recent overrun
//   timeout_err  sticky: a grant hit the per-slot watchdog
//
// Build option
//   VBLANK_SCHED_TIMEOUT_EN : when defined, a grant is withdrawn after
//   MAX_SLOT_CYCLES cycles without done and timeout_err is raised. When
//   undefined, no watchdog exists and timeout_err is constant 0.

module vblank_scheduler #(
  parameter int N_REQ           = 3,
  parameter int V_ACTIVE        = 480,
  parameter int MAX_SLOT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hcnt,
  input  logic [9:0]       vcnt,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             frame_tick,
  output logic             busy,
  output logic             overrun,
  output logic [N_REQ-1:0] skipped,
  output logic             timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             frame_tick_q, frame_tick_d;
  logic             overrun_q, overrun_d;
  logic [N_REQ-1:0] skipped_q, skipped_d;

  logic             frame_start;
  logic             vblank_end;
  logic             served_now;
  logic [N_REQ-1:0] remaining;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] pick_onehot;

  assign frame_start = (vcnt == 10'(V_ACTIVE)) && (hcnt == 10'd0);
  assign vblank_end  = (vcnt == 10'd0) && (hcnt == 10'd0);

`ifdef VBLANK_SCHED_TIMEOUT_EN
  localparam int SLOT_W = $clog2(MAX_SLOT_CYCLES);

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              slot_expired;

  assign slot_expired = (slot_cnt_q == SLOT_W'(MAX_SLOT_CYCLES - 1));
  assign timeout_err  = timeout_err_q;
`else
  // Watchdog not built; the parameter is kept only for a uniform interface.
  logic unused_max_slot_cfg;
  assign unused_max_slot_cfg = (MAX_SLOT_CYCLES > 0);
  assign timeout_err = 1'b0;
`endif

  // Round-robin search: first pending bit strictly after last, wrapping.
  always_comb begin
    int cand;
    cand       = 0;
    pick_idx   = last_q;
    pick_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_q) + i) % N_REQ;
      if (!pick_found && pending_q[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pick_onehot
    assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
  end

  // While serving, last_q is the granted index. A done on the same edge as
  // the end of vblank still counts, so it is removed before skipping.
  always_comb begin
    served_now = (state_q == ST_SERVE) && done[last_q];
    remaining  = pending_q;
    if (served_now) begin
      remaining[last_q] = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    last_d       = last_q;
    grant_d      = grant_q;
    frame_tick_d = 1'b0;
    overrun_d    = overrun_q;
    skipped_d    = skipped_q;
`ifdef VBLANK_SCHED_TIMEOUT_EN
    slot_cnt_d    = slot_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      ST_ARB: begin
        if (!pick_found) begin
          state_d = ST_IDLE;
        end else begin
          grant_d = pick_onehot;
          last_d  = pick_idx;
          state_d = ST_SERVE;
`ifdef VBLANK_SCHED_TIMEOUT_EN
          slot_cnt_d = '0;
`endif
        end
      end
      ST_SERVE: begin
        if (served_now) begin
          grant_d   = '0;
          pending_d = remaining;
          state_d   = ST_ARB;
        end
`ifdef VBLANK_SCHED_TIMEOUT_EN
        else if (slot_expired) begin
          grant_d           = '0;
          pending_d[last_q] = 1'b0;
          timeout_err_d     = 1'b1;
          state_d           = ST_ARB;
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
`endif
      end
      default: ;
    endcase

    // End of vblank overrides normal sequencing; a watchdog expiring on this
    // same edge is not reported because the slot is being skipped anyway.
    if (vblank_end && (state_q != ST_IDLE)) begin
      grant_d   = '0;
      pending_d = '0;
      state_d   = ST_IDLE;
`ifdef VBLANK_SCHED_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
`endif
      if (remaining != '0) begin
        skipped_d = remaining;
        overrun_d = 1'b1;
      end
    end

    if (frame_start) begin
      frame_tick_d = 1'b1;
      pending_d    = req;
      grant_d      = '0;
      state_d      = ST_ARB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      grant_q      <= '0;
      frame_tick_q <= 1'b0;
      overrun_q    <= 1'b0;
      skipped_q    <= '0;
`ifdef VBLANK_SCHED_TIMEOUT_EN
      slot_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      frame_tick_q <= frame_tick_d;
      overrun_q    <= overrun_d;
      skipped_q    <= skipped_d;
`ifdef VBLANK_SCHED_TIMEOUT_EN
      slot_cnt_q    <= slot_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign frame_tick = frame_tick_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;
  assign skipped    = skipped_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Testbench for vblank_scheduler. Frames are driven by placing the sync
// counters directly at their frame-start / end-of-vblank values. A reference
// model plans each frame (grant order, grant windows, skipped set) from the
// round-robin rules and pushes expectations into queues; a monitor pops them
// as grants and frame ticks appear on the DUT outputs.

module tb_vblank_scheduler;

  localparam int N_REQ    = 3;
  localparam int V_ACTIVE = 480;
`ifdef VBLANK_SCHED_TIMEOUT_EN
  localparam int MAX_SLOT = 16;
`else
  localparam int MAX_SLOT = 256;
`endif
  localparam int NEVER = 1 << 30;

  logic             clk = 1'b0;
  logic             reset;
  logic [9:0]       hcnt, vcnt;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done = '0;
  logic [N_REQ-1:0] grant;
  logic             frame_tick, busy, overrun, timeout_err;
  logic [N_REQ-1:0] skipped;

  always #20 clk = ~clk;

  vblank_scheduler #(
    .N_REQ(N_REQ), .V_ACTIVE(V_ACTIVE), .MAX_SLOT_CYCLES(MAX_SLOT)
  ) dut (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .req(req), .done(done),
    .grant(grant), .frame_tick(frame_tick), .busy(busy), .overrun(overrun),
    .skipped(skipped), .timeout_err(timeout_err)
  );

  // Cycle label: value of cyc seen at the negedge after posedge number cyc.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [N_REQ-1:0] mask;
    int               start;
    int               stop;
  } gev_t;

  gev_t exp_q[$];
  int   tick_q[$];

  // Per-requester done latency in cycles after grant; 0 means never.
  int lat[N_REQ];

  int               model_last;
  logic             exp_overrun;
  logic [N_REQ-1:0] exp_skipped;
  logic             exp_timeout;

  // Plan one frame whose start edge is k and end-of-vblank edge is e.
  task automatic plan_frame(input logic [N_REQ-1:0] rq, input int k, input int e,
                            input bit commit, output int last_done,
                            output logic [N_REQ-1:0] unserved);
    logic [N_REQ-1:0] pend;
    int ptr, t, idx, eff;
    bit stall, stop, tmo;
    pend = rq; ptr = model_last; t = k + 1;
    unserved = '0; last_done = k; stop = 0; tmo = 0;
    while (pend != '0 && !stop) begin
      idx = -1;
      for (int s = 1; s <= N_REQ; s++) begin
        if (idx < 0 && pend[(ptr + s) % N_REQ]) idx = (ptr + s) % N_REQ;
      end
      if (t >= e) begin
        unserved = pend;
        stop = 1;
      end else begin
        ptr = idx;
        pend[idx] = 1'b0;
        stall = (lat[idx] == 0);
`ifdef VBLANK_SCHED_TIMEOUT_EN
        eff = stall ? MAX_SLOT : lat[idx];
`else
        eff = stall ? NEVER : lat[idx];
`endif
        if (t + eff > e || (stall && t + eff >= e)) begin
          if (commit) exp_q.push_back('{mask: N_REQ'(1) << idx, start: t, stop: e});
          unserved = pend;
          unserved[idx] = 1'b1;
          stop = 1;
        end else begin
          if (commit) exp_q.push_back('{mask: N_REQ'(1) << idx, start: t, stop: t + eff});
          if (stall) tmo = 1;
          last_done = t + eff;
          t = t + eff + 1;
        end
      end
    end
    if (commit) begin
      model_last = ptr;
      if (unserved != '0) begin
        exp_overrun = 1'b1;
        exp_skipped = unserved;
      end
      if (tmo) exp_timeout = 1'b1;
    end
  endtask

  // Called at a negedge. vlen = cycles from frame-start edge to end edge;
  // align places the end edge exactly on the last requester's done edge.
  task automatic run_frame(input logic [N_REQ-1:0] rq, input int vlen, input bit align);
    int k, e, ld, fin;
    logic [N_REQ-1:0] un;
    req  = rq;
    vcnt = 10'(V_ACTIVE);
    hcnt = 10'd0;
    k = cyc + 1;
    if (align) begin
      plan_frame(rq, k, NEVER, 0, ld, un);
      e = ld;
    end else begin
      e = k + vlen;
    end
    plan_frame(rq, k, e, 1, ld, un);
    fin = (un != '0) ? e : ((ld + 1 < e) ? ld + 1 : e);
    tick_q.push_back(k);
    @(negedge clk);
    vcnt = 10'(V_ACTIVE + 1);
    hcnt = 10'd17;
    while (cyc < e + 2) begin
      check("busy", 32'(busy), 32'((cyc >= k && cyc < fin) ? 1 : 0));
      if (cyc == k + 2) req = N_REQ'($urandom);
      if (cyc == e - 1) begin
        vcnt = 10'd0; hcnt = 10'd0;
      end else if (cyc == e) begin
        vcnt = 10'd0; hcnt = 10'd1;
      end
      @(negedge clk);
    end
    check("overrun", 32'(overrun), 32'(exp_overrun));
    check("skipped", 32'(skipped), 32'(exp_skipped));
    check("timeout_err", 32'(timeout_err), 32'(exp_timeout));
    check("grant_idle", 32'(grant), 32'd0);
  endtask

  task automatic reset_test();
    int k;
    lat = '{0, 0, 0};
    req = 3'b010;
    vcnt = 10'(V_ACTIVE);
    hcnt = 10'd0;
    k = cyc + 1;
    tick_q.push_back(k);
    exp_q.push_back('{mask: 3'b010, start: k + 1, stop: k + 4});
    @(negedge clk);
    vcnt = 10'(V_ACTIVE + 1);
    hcnt = 10'd17;
    @(negedge clk);
    @(negedge clk);
    check("mid_serve_grant", 32'(grant), 32'h2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_skipped", 32'(skipped), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    model_last = N_REQ - 1;
    exp_overrun = 1'b0;
    exp_skipped = '0;
    exp_timeout = 1'b0;
  endtask

  // Requester behaviour: assert done on the granted bit lat cycles after the
  // grant appeared; random chatter on non-granted bits must be ignored.
  int               resp_start = 0;
  logic [N_REQ-1:0] resp_prev = '0;
  logic [N_REQ-1:0] resp_d;
  always @(negedge clk) begin
    resp_d = N_REQ'($urandom) & ~grant;
    if (grant != '0 && grant != resp_prev) resp_start = cyc;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i] && lat[i] != 0 && (cyc - resp_start) == lat[i] - 1) resp_d[i] = 1'b1;
    end
    done = resp_d;
    resp_prev = grant;
  end

  // Monitor: one line per completed grant and per frame tick.
  logic [N_REQ-1:0] mon_prev = '0;
  int               mon_start = 0;
  gev_t             mon_ev;
  always @(negedge clk) begin
    if (mon_prev != '0 && grant != mon_prev) begin
      if (exp_q.size() == 0) begin
        check("grant_unexpected", 32'(mon_prev), 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        $display("grant %b cycles %0d..%0d (expected %b %0d..%0d)",
                 mon_prev, mon_start, cyc, mon_ev.mask, mon_ev.start, mon_ev.stop);
        check("grant_mask", 32'(mon_prev), 32'(mon_ev.mask));
        check("grant_start", 32'(mon_start), 32'(mon_ev.start));
        check("grant_stop", 32'(cyc), 32'(mon_ev.stop));
      end
    end
    if (grant != '0 && grant != mon_prev) mon_start = cyc;
    if (frame_tick) begin
      if (tick_q.size() == 0) begin
        check("frame_tick_unexpected", 32'(frame_tick), 32'd0);
      end else begin
        $display("frame_tick at cycle %0d", cyc);
        check("frame_tick_cycle", 32'(cyc), 32'(tick_q.pop_front()));
      end
    end
    mon_prev = grant;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    hcnt  = 10'd5;
    vcnt  = 10'd5;
    lat   = '{1, 1, 1};
    model_last  = N_REQ - 1;
    exp_overrun = 1'b0;
    exp_skipped = '0;
    exp_timeout = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_tick", 32'(frame_tick), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_skipped", 32'(skipped), 32'd0);
    check("reset_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    lat = '{4, 4, 4}; run_frame(3'b111, 60, 0);   // 001, 010, 100
    lat = '{3, 3, 3}; run_frame(3'b001, 40, 0);   // only requester 0
    lat = '{2, 5, 3}; run_frame(3'b111, 50, 0);   // 010, 100, 001
    lat = '{3, 4, 2}; run_frame(3'b011, 0, 1);    // done on the end edge
    lat = '{0, 3, 3}; run_frame(3'b011, 40, 0);   // requester 0 stalls
    reset_test();
    lat = '{2, 2, 2}; run_frame(3'b111, 40, 0);   // requester 0 first again
`ifdef VBLANK_SCHED_TIMEOUT_EN
    lat = '{3, 0, 3}; run_frame(3'b110, 80, 0);   // requester 1 times out
`endif
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < N_REQ; i++) begin
        lat[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      end
      run_frame(N_REQ'($urandom), int'($urandom_range(3, 40)), 0);
    end

    repeat (4) @(negedge clk);
    check("grants_outstanding", 32'(exp_q.size()), 32'd0);
    check("ticks_outstanding", 32'(tick_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
